// File: rtl/priority_encoder_seq_pkg.sv
// Shared constants and state encoding for the sequential priority encoder.
package priority_encoder_seq_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/priority_encoder_seq_if.sv
// Load and output handshake bundle for the sequential priority encoder.
interface priority_encoder_seq_if;
    import priority_encoder_seq_pkg::*;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             zero_err;
    logic             busy;

    modport master (
        output load_valid, d, out_ready,
        input  load_ready, out_valid, out_idx, out_last, zero_err, busy
    );

    modport slave (
        input  load_valid, d, out_ready,
        output load_ready, out_valid, out_idx, out_last, zero_err, busy
    );

endinterface

// File: rtl/priority_encoder_seq_pri_enc8.sv
// Combinational highest-set-bit encoder with a one-hot detect flag.
module pri_enc8
    import priority_encoder_seq_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             single
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential 8-to-3 priority encoder: emits set-bit indices highest first.
module priority_encoder_seq
    import priority_encoder_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    priority_encoder_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             load_ready_q, load_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_err_q, zero_err_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] hi_idx;
    logic             hi_single;

    pri_enc8 u_enc (
        .vec    (pending_q),
        .idx    (hi_idx),
        .single (hi_single)
    );

    // Next-state, pending update and registered-output decode.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_valid && load_ready_q) begin
                    if (bus.d != '0) begin
                        pending_d = bus.d;
                        state_d   = EMIT;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << hi_idx);
                    if (hi_single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        load_ready_d = (state_d == IDLE);
        out_valid_d  = (state_d == EMIT);
        busy_d       = (state_d == EMIT);
    end

    // State and output registers; load_ready rises on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            load_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            zero_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            out_valid_q  <= out_valid_d;
            zero_err_q   <= zero_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.zero_err   = zero_err_q;
    assign bus.busy       = busy_q;
    assign bus.out_idx    = hi_idx;
    assign bus.out_last   = hi_single;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Scoreboard bench for priority_encoder_seq.
module tb_priority_encoder_seq;
    import priority_encoder_seq_pkg::*;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    beat_t exp_q[$];

    priority_encoder_seq_if bus ();

    priority_encoder_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every accepted beat is compared with the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got idx %0d with no beat expected", bus.out_idx);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_idx != e.idx || bus.out_last != e.last) begin
                    errors++;
                    $display("FAIL beat: got idx %0d last %0d expected idx %0d last %0d",
                             bus.out_idx, bus.out_last, e.idx, e.last);
                end
            end
        end
    end

    // Wait for load_ready, present v for one edge, queue its expected beats.
    task automatic do_load(input logic [7:0] v);
        int    n   = 0;
        int    rem = $countones(v);
        beat_t e;
        while (!bus.load_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("load_ready_timeout", int'(bus.load_ready), 1);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                e.idx  = IDX_W'(i);
                e.last = (rem == 1);
                exp_q.push_back(e);
                rem--;
            end
        end
        bus.load_valid = 1'b1;
        bus.d          = v;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        bus.d          = '0;
    endtask

    // Drain remaining beats with random back-pressure, bounded.
    task automatic drain(input bit rnd);
        int n = 0;
        while (!(bus.load_ready && exp_q.size() == 0) && n < 200) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1; n++;
        end
        bus.out_ready = 1'b1;
        chk("drain_timeout", (n < 200) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.d          = '0;
        bus.out_ready  = 1'b1;
        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_zero_err", int'(bus.zero_err), 0);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_load_ready", int'(bus.load_ready), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("load_ready_after_rst", int'(bus.load_ready), 1);

        // 1010_0110: indices 7,5,2,1 on consecutive cycles.
        do_load(8'b1010_0110);
        chk("a6_valid0", int'(bus.out_valid), 1);
        chk("a6_idx0", int'(bus.out_idx), 7);
        chk("a6_busy", int'(bus.busy), 1);
        chk("a6_ready_low", int'(bus.load_ready), 0);
        @(posedge clk); #1;
        chk("a6_idx1", int'(bus.out_idx), 5);
        chk("a6_last1", int'(bus.out_last), 0);
        @(posedge clk); #1;
        chk("a6_idx2", int'(bus.out_idx), 2);
        @(posedge clk); #1;
        chk("a6_idx3", int'(bus.out_idx), 1);
        chk("a6_last3", int'(bus.out_last), 1);
        @(posedge clk); #1;
        chk("a6_idle_ready", int'(bus.load_ready), 1);
        chk("a6_idle_valid", int'(bus.out_valid), 0);

        // Single bit 0.
        do_load(8'b0000_0001);
        chk("b01_valid", int'(bus.out_valid), 1);
        chk("b01_idx", int'(bus.out_idx), 0);
        chk("b01_last", int'(bus.out_last), 1);
        @(posedge clk); #1;
        chk("b01_idle", int'(bus.load_ready), 1);

        // All-zero vector: one-cycle zero_err, nothing emitted.
        do_load(8'h00);
        chk("z_err", int'(bus.zero_err), 1);
        chk("z_valid", int'(bus.out_valid), 0);
        chk("z_ready", int'(bus.load_ready), 1);
        @(posedge clk); #1;
        chk("z_err_pulse", int'(bus.zero_err), 0);
        chk("z_valid2", int'(bus.out_valid), 0);

        // 0xFF with a 3-cycle stall and a stray load during EMIT.
        bus.out_ready = 1'b0;
        do_load(8'hFF);
        chk("ff_stall0", int'(bus.out_idx), 7);
        chk("ff_valid0", int'(bus.out_valid), 1);
        bus.load_valid = 1'b1;
        bus.d          = 8'h01;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        bus.d          = '0;
        chk("ff_stall1", int'(bus.out_idx), 7);
        chk("ff_ready_low", int'(bus.load_ready), 0);
        @(posedge clk); #1;
        chk("ff_stall2", int'(bus.out_idx), 7);
        chk("ff_last_stall", int'(bus.out_last), 0);
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.load_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ff_emit_cycles", n, 8);

        // Reset mid-emission after the first beat.
        do_load(8'b1100_0000);
        chk("c0_idx0", int'(bus.out_idx), 7);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_last", int'(bus.out_last), 0);
        chk("mid_rst_idx", int'(bus.out_idx), 0);
        exp_q.delete();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ready", int'(bus.load_ready), 1);
        do_load(8'b0000_1000);
        chk("08_idx", int'(bus.out_idx), 3);
        chk("08_last", int'(bus.out_last), 1);
        drain(1'b0);

        // Sweep of every nonzero vector with random back-pressure.
        for (int v = 1; v < 256; v++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            do_load(8'(v));
            drain(1'b1);
        end

        @(posedge clk); #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
Name: priority_encoder_seq

Overview:
- Sequential 8-to-3 priority encoder. It is the encode-side counterpart of the team's 3-to-8 decoder.
- Accepts a multi-hot 8-bit vector through a valid/ready load handshake.
- Emits the 3-bit index of each set bit, one per accepted output beat, highest index first.
- Clears each bit as it is emitted and returns to idle after the last one. Feeds the decoder-based arithmetic blocks and the lab test harness.

Parameters:
- WIDTH, 8, request vector width; must be a power of two.
- IDX_W, 3, encoded index width; must equal log2(WIDTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  a new vector is presented on d.
- load_ready  output  1  block is idle and can accept a vector.
- d  input  WIDTH  request vector to encode.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts the current out_idx.
- out_idx  output  IDX_W  index of the highest remaining set bit.
- out_last  output  1  the current beat is the final index for this vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was offered.
- busy  output  1  a vector is being emitted.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0, zero_err=0, busy=0.
  - load_ready=1 from the first rising edge after rst deasserts.
  - Reset asserted mid-operation discards pending immediately; no partial beats follow.
- States: IDLE, EMIT. All outputs are registered except out_idx and out_last, which are combinational from the pending register.
- IDLE:
  - load_ready=1, out_valid=0, busy=0.
  - load_valid=1 and d!=0: pending<=d, state<=EMIT.
  - load_valid=1 and d==0: zero_err=1 for exactly the next cycle; state stays IDLE; nothing is emitted.
- EMIT:
  - load_ready=0, busy=1, out_valid=1. load_valid is ignored.
  - out_idx = highest i with pending[i]=1.
  - out_last = 1 when pending has exactly one bit set.
  - out_valid=1 and out_ready=1: clear pending[out_idx].
    - If out_last=1: state<=IDLE. load_ready is 1 and out_valid is 0 in the next cycle.
    - Otherwise: stay in EMIT; the next index appears in the next cycle.
  - out_ready=0: out_idx and out_last hold stable for as long as the stall lasts.
- Latency:
  - Load accepted on edge N gives the first out_valid in cycle N+1.
  - A vector with k set bits needs at least k output cycles, then 1 idle cycle before the next load.
- Back-to-back: at least one IDLE cycle separates vectors. Load and the last emit never happen on the same edge.
- Width rules: IDX_W = log2(WIDTH). out_idx never exceeds WIDTH-1. Priority is strictly highest-index-first.

Decomposition:
- Shared package holds:
  - constants WIDTH and IDX_W
  - state encodings IDLE=1'b0, EMIT=1'b1
- One combinational sub-module, pri_enc8.
  - Input: WIDTH-bit vector.
  - Outputs: IDX_W index of the highest set bit, plus a "single" flag (exactly one bit set).
  - Instantiated once on pending.
- The top level holds the FSM, the pending register, the handshake logic and the zero_err pulse.

Test Plan:
- Reset, then load d=8'b1010_0110 with out_ready held 1.
  - Required: out_idx sequence 7,5,2,1 on consecutive cycles.
  - out_last=1 only on idx 1; load_ready=1 on the following cycle.
- Load d=8'b0000_0001.
  - Required: single beat out_idx=0, out_last=1, first out_valid one cycle after the load.
- Load d=8'h00.
  - Required: zero_err high for exactly 1 cycle, out_valid stays 0, load_ready stays 1.
- Load d=8'hFF, hold out_ready=0 for 3 cycles, then out_ready=1.
  - Required: out_idx=7 stable through the stall, then 7..0 over 8 cycles.
  - load_valid pulses during EMIT have no effect.
- Load d=8'b1100_0000, assert rst asynchronously mid-cycle after the first beat.
  - Required: out_valid, busy and pending drop to 0 immediately; load_ready=1 after rst release.
  - A new load of 8'b0000_1000 yields out_idx=3, out_last=1.
- Random sweep of all 255 nonzero vectors with random out_ready.
  - Required: the emitted index set equals the set-bit set, in descending order.
  - out_last=1 on exactly one beat per vector.
